// File: rtl/inst_loader_if.sv
// Bus between the bit-serial CPU front end and its environment: raw button/switch
// inputs, the busy flag from the control FSM, and the loaded instruction.
interface inst_loader_if #(
   parameter int INST_W = 12
);
   logic                         btn_raw;
   logic                         din_raw;
   logic                         busy;
   logic                         btn_edge;
   logic                         inst_done;
   logic [3:0]                   opcode;
   logic [INST_W-5:0]            operand;
   logic [$clog2(INST_W+1)-1:0]  bit_cnt;
   logic [1:0]                   state_dbg;

   // Handshake: btn_edge is a one-cycle strobe with no backpressure. opcode/operand
   // are valid while inst_done is high. busy holds the loader out of LOAD until the
   // downstream datapath has gone busy and then idle again.
   modport master (
      output btn_raw, din_raw, busy,
      input  btn_edge, inst_done, opcode, operand, bit_cnt, state_dbg
   );

   modport slave (
      input  btn_raw, din_raw, busy,
      output btn_edge, inst_done, opcode, operand, bit_cnt, state_dbg
   );
endinterface

// File: rtl/inst_loader.sv
// Synchronizes and debounces a push-button and serial data switch, then shifts an
// INST_W-bit instruction in MSB first, one bit per debounced press.
module inst_loader #(
   parameter int INST_W     = 12,
   parameter int DEB_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_loader_if.slave  bus
);
   localparam int CNT_W = $clog2(INST_W + 1);
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(INST_W - 1);

   typedef enum logic [1:0] {
      LOAD      = 2'd0,
      READY     = 2'd1,
      EXEC_WAIT = 2'd2,
      EXEC_RUN  = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic                btn_meta, btn_sync, din_meta, din_sync;
   logic                btn_db, btn_edge, inst_done;
   logic [DEB_W-1:0]    deb;
   logic [INST_W-1:0]   shreg;
   logic [CNT_W-1:0]    bit_cnt;
   logic                db_flip, shift_en, cnt_clr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         din_meta <= 1'b0;
         din_sync <= 1'b0;
      end else begin
         btn_meta <= bus.btn_raw;
         btn_sync <= btn_meta;
         din_meta <= bus.din_raw;
         din_sync <= din_meta;
      end
   end

   // A level change is accepted only after DEB_CYCLES consecutive differing samples.
   assign db_flip = (btn_sync != btn_db) && (deb == DEB_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_db   <= 1'b0;
         deb      <= '0;
         btn_edge <= 1'b0;
      end else begin
         btn_edge <= db_flip & btn_sync;
         if (btn_sync == btn_db) begin
            deb <= '0;
         end else if (db_flip) begin
            btn_db <= btn_sync;
            deb    <= '0;
         end else begin
            deb <= deb + DEB_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         LOAD: begin
            if (btn_edge) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) state_nxt = READY;
            end
         end
         READY:     if (btn_edge) state_nxt = EXEC_WAIT;
         EXEC_WAIT: if (bus.busy) state_nxt = EXEC_RUN;
         EXEC_RUN: begin
            if (!bus.busy) begin
               state_nxt = LOAD;
               cnt_clr   = 1'b1;
            end
         end
         default:   state_nxt = LOAD;
      endcase
   end

   // shreg is not cleared when a new load starts; old bits are shifted out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= LOAD;
         inst_done <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         inst_done <= (state_nxt == READY);
         if (shift_en) begin
            shreg   <= {shreg[INST_W-2:0], din_sync};
            bit_cnt <= bit_cnt + CNT_W'(1);
         end else if (cnt_clr) begin
            bit_cnt <= '0;
         end
      end
   end

   assign bus.btn_edge  = btn_edge;
   assign bus.inst_done = inst_done;
   assign bus.opcode    = shreg[INST_W-1:INST_W-4];
   assign bus.operand   = shreg[INST_W-5:0];
   assign bus.bit_cnt   = bit_cnt;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: a window-based behavioural model checked every cycle,
// directed scenarios with literal expectations, and a randomized press phase.
module tb_inst_loader;
   localparam int INST_W = 12;
   localparam int DEB    = 4;
   localparam int P_LOAD = 0, P_READY = 1, P_WAIT = 2, P_RUN = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   chk_en = 1'b0;
   int   edge_cnt = 0;
   int   last_edge_cyc = -1;
   logic last_edge_done = 1'b0;

   inst_loader_if #(.INST_W(INST_W)) bus ();

   inst_loader #(.INST_W(INST_W), .DEB_CYCLES(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural model: button accepted when the last DEB synchronized samples all
   // disagree with the debounced level; instruction built by plain shifting.
   int          m_phase = P_LOAD;
   logic [11:0] m_shreg = '0;
   int          m_cnt = 0;
   bit          m_done = 0, m_edge = 0, m_db = 0;
   bit          m_s1 = 0, m_sync = 0, m_dmeta = 0, m_dsync = 0;
   bit          m_win[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = P_LOAD; m_shreg = '0; m_cnt = 0; m_done = 0; m_edge = 0;
         m_db = 0; m_s1 = 0; m_sync = 0; m_dmeta = 0; m_dsync = 0;
         m_win.delete();
      end else begin
         bit all_flip;
         case (m_phase)
            P_LOAD: if (m_edge) begin
               m_shreg = {m_shreg[10:0], m_dsync};
               m_cnt++;
               if (m_cnt == INST_W) m_phase = P_READY;
            end
            P_READY: if (m_edge) m_phase = P_WAIT;
            P_WAIT:  if (bus.busy) m_phase = P_RUN;
            default: if (!bus.busy) begin m_phase = P_LOAD; m_cnt = 0; end
         endcase
         m_done = (m_phase == P_READY);
         m_win.push_back(m_sync);
         if (m_win.size() > DEB) void'(m_win.pop_front());
         m_edge = 0;
         if (m_win.size() == DEB) begin
            all_flip = 1;
            foreach (m_win[i]) if (m_win[i] == m_db) all_flip = 0;
            if (all_flip) begin
               m_db = !m_db;
               m_edge = m_db;
               m_win.delete();
            end
         end
         m_sync = m_s1;  m_s1 = bus.btn_raw;
         m_dsync = m_dmeta; m_dmeta = bus.din_raw;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors < 30)
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("btn_edge",  bus.btn_edge,  m_edge);
         cmp("inst_done", bus.inst_done, m_done);
         cmp("opcode",    bus.opcode,    m_shreg[11:8]);
         cmp("operand",   bus.operand,   m_shreg[7:0]);
         cmp("bit_cnt",   bus.bit_cnt,   m_cnt);
         cmp("state",     bus.state_dbg, m_phase);
         if (bus.btn_edge === 1'b1) begin
            edge_cnt++;
            last_edge_cyc  = cyc;
            last_edge_done = bus.inst_done;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic press(input bit d, input int hold, input int gap);
      bus.din_raw = d;
      step(3);
      bus.btn_raw = 1'b1;
      step(hold);
      bus.btn_raw = 1'b0;
      step(gap);
   endtask

   task automatic load_word(input logic [11:0] w, input int n);
      for (int i = 0; i < n; i++) press(w[11-i], DEB + 2, DEB + 3);
   endtask

   initial begin
      int c0, e0;
      logic [11:0] w;
      bus.btn_raw = 0; bus.din_raw = 0; bus.busy = 0;
      step(1);
      rst_n = 1'b0;
      step(2);
      chk_en = 1'b1;
      cmp("reset_bit_cnt", bus.bit_cnt, 0);
      cmp("reset_opcode",  bus.opcode, 0);
      cmp("reset_done",    bus.inst_done, 0);
      rst_n = 1'b1;
      step(2);

      // Short synchronized glitch, then a clean 6-cycle pulse
      e0 = edge_cnt;
      bus.btn_raw = 1; step(3); bus.btn_raw = 0; step(8);
      cmp("glitch_edges", edge_cnt - e0, 0);
      cmp("glitch_cnt",   bus.bit_cnt, 0);
      c0 = cyc;
      bus.btn_raw = 1; step(6); bus.btn_raw = 0; step(10);
      cmp("pulse_edges",   edge_cnt - e0, 1);
      cmp("pulse_latency", last_edge_cyc - c0, 6);
      cmp("pulse_cnt",     bus.bit_cnt, 1);

      // Full instruction 0x85A
      do_reset();
      load_word(12'h85A, 12);
      cmp("load_done",    bus.inst_done, 1);
      cmp("load_opcode",  bus.opcode, 4'h8);
      cmp("load_operand", bus.operand, 8'h5A);
      cmp("load_cnt",     bus.bit_cnt, 12);
      press(1'b1, DEB + 2, DEB + 3);
      cmp("exec_press_done", last_edge_done, 1);
      cmp("exec_wait_done",  bus.inst_done, 0);
      cmp("exec_wait_state", bus.state_dbg, P_WAIT);
      cmp("exec_opcode",     bus.opcode, 4'h8);

      // Presses while busy leave the instruction alone
      bus.busy = 1; bus.btn_raw = 1; step(6);
      bus.btn_raw = 0; step(5);
      bus.btn_raw = 1; step(7);
      bus.busy = 0; bus.btn_raw = 0; step(10);
      cmp("busy_operand", bus.operand, 8'h5A);
      cmp("busy_opcode",  bus.opcode, 4'h8);
      cmp("busy_cnt",     bus.bit_cnt, 0);
      cmp("busy_state",   bus.state_dbg, P_LOAD);

      // Reset in the middle of a load
      load_word(12'hF30, 5);
      cmp("mid_cnt", bus.bit_cnt, 5);
      rst_n = 0; step(1); rst_n = 1;
      cmp("mid_rst_cnt",    bus.bit_cnt, 0);
      cmp("mid_rst_opcode", bus.opcode, 0);
      cmp("mid_rst_done",   bus.inst_done, 0);
      step(1);
      load_word(12'h3C7, 11);
      cmp("mid_11_done", bus.inst_done, 0);
      press(1'b1, DEB + 2, DEB + 3);
      cmp("mid_12_done",    bus.inst_done, 1);
      cmp("mid_12_operand", bus.operand, 8'hC7);

      // Button held through reset release
      bus.btn_raw = 1; rst_n = 0; e0 = edge_cnt;
      step(3);
      rst_n = 1; c0 = cyc;
      step(10);
      cmp("held_edges",   edge_cnt - e0, 1);
      cmp("held_latency", last_edge_cyc - c0, 6);
      cmp("held_cnt",     bus.bit_cnt, 1);
      bus.btn_raw = 0; step(8);

      // Bouncing press
      e0 = edge_cnt;
      for (int i = 0; i < 8; i++) begin bus.btn_raw = ~bus.btn_raw; step(1); end
      bus.btn_raw = 1; step(10);
      bus.btn_raw = 0; step(10);
      cmp("bounce_edges", edge_cnt - e0, 1);

      // Randomized presses, glitches, busy activity and occasional resets
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: press(1'($urandom_range(0, 1)), $urandom_range(1, 8),
                                    $urandom_range(1, 8));
            6, 7: begin bus.busy = 1'($urandom_range(0, 1)); step($urandom_range(1, 6)); end
            8: for (int j = 0; j < int'($urandom_range(1, 10)); j++) begin
                  bus.btn_raw = 1'($urandom_range(0, 1));
                  bus.din_raw = 1'($urandom_range(0, 1));
                  step(1);
               end
            default: if ($urandom_range(0, 3) == 0) begin
                  rst_n = 0; step($urandom_range(1, 2)); rst_n = 1;
               end else step(2);
         endcase
      end
      bus.btn_raw = 0; bus.busy = 0;
      step(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
